// File: rtl/writeback_arbiter_pkg.sv
// Shared defaults for the register-file write side: data width, register
// index width, architectural register count and load-queue sizing.
package writeback_arbiter_pkg;

    localparam int DEF_XLEN           = 32;
    localparam int DEF_REG_ADDR_WIDTH = 5;
    localparam int DEF_REG_COUNT      = 32;
    localparam int DEF_LQ_DEPTH       = 2;

    // Width of an occupancy counter able to hold 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/wb_load_queue.sv
// In-order load-result FIFO. Power-of-two depth so pointers wrap naturally;
// push and pop in the same cycle both take effect.
module wb_load_queue
    import writeback_arbiter_pkg::*;
#(
    parameter int DEPTH = DEF_LQ_DEPTH,
    parameter int W     = DEF_XLEN + DEF_REG_ADDR_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  logic [W-1:0]                push_data,
    input  logic                        pop,
    output logic [W-1:0]                pop_data,
    output logic                        full,
    output logic                        empty,
    output logic [cnt_width(DEPTH)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_width(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked entirely by count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Register-file write port: ALU results win over queued load results; a
// destination scoreboard reports pending writes to decode's source operands.
module writeback_arbiter
    import writeback_arbiter_pkg::*;
#(
    parameter int XLEN           = DEF_XLEN,
    parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH,
    parameter int LQ_DEPTH       = DEF_LQ_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      issue_valid,
    input  logic [REG_ADDR_WIDTH-1:0] issue_rd,
    input  logic                      alu_valid,
    input  logic [REG_ADDR_WIDTH-1:0] alu_rd,
    input  logic [XLEN-1:0]           alu_data,
    input  logic                      ld_valid,
    output logic                      ld_ready,
    input  logic [REG_ADDR_WIDTH-1:0] ld_rd,
    input  logic [XLEN-1:0]           ld_data,
    input  logic [REG_ADDR_WIDTH-1:0] rs1,
    input  logic [REG_ADDR_WIDTH-1:0] rs2,
    output logic                      rs1_busy,
    output logic                      rs2_busy,
    output logic                      we,
    output logic [REG_ADDR_WIDTH-1:0] rd,
    output logic [XLEN-1:0]           rd_data
);

    localparam int REG_COUNT = 2 ** REG_ADDR_WIDTH;
    localparam int EW        = REG_ADDR_WIDTH + XLEN;

    logic                             lq_push;
    logic                             lq_pop;
    logic                             lq_full;
    logic                             lq_empty;
    logic [EW-1:0]                    lq_head;
    logic [cnt_width(LQ_DEPTH)-1:0]   lq_count;
    logic [REG_ADDR_WIDTH-1:0]        lq_rd;
    logic [XLEN-1:0]                  lq_data;
    logic [REG_COUNT-1:0]             pending;
    logic [REG_COUNT-1:0]             pending_nxt;

    // Readiness looks at occupancy only, never at a same-cycle pop.
    assign ld_ready = rst && !lq_full;
    assign lq_push  = ld_valid && ld_ready;
    assign lq_pop   = !alu_valid && !lq_empty;
    assign {lq_rd, lq_data} = lq_head;

    wb_load_queue #(
        .DEPTH (LQ_DEPTH),
        .W     (EW)
    ) u_lq (
        .clk       (clk),
        .rst       (rst),
        .push      (lq_push),
        .push_data ({ld_rd, ld_data}),
        .pop       (lq_pop),
        .pop_data  (lq_head),
        .full      (lq_full),
        .empty     (lq_empty),
        .count     (lq_count)
    );

    // Commit clears on the same edge the register file writes; a new issue
    // to the same register on that edge keeps it pending.
    always_comb begin
        pending_nxt = pending;
        if (we) pending_nxt[rd] = 1'b0;
        if (issue_valid && issue_rd != '0) pending_nxt[issue_rd] = 1'b1;
        pending_nxt[0] = 1'b0;
    end

    assign rs1_busy = (rs1 != '0) && pending[rs1];
    assign rs2_busy = (rs2 != '0) && pending[rs2];

    always_ff @(posedge clk) begin
        if (!rst) begin
            we      <= 1'b0;
            rd      <= '0;
            rd_data <= '0;
            pending <= '0;
        end else begin
            pending <= pending_nxt;
            if (alu_valid) begin
                we      <= (alu_rd != '0);
                rd      <= alu_rd;
                rd_data <= alu_data;
            end else if (!lq_empty) begin
                we      <= (lq_rd != '0);
                rd      <= lq_rd;
                rd_data <= lq_data;
            end else begin
                we      <= 1'b0;
            end
        end
    end

endmodule
